// File: rtl/tape_meter_pkg.sv
// Shared types and constants for the cassette level/position meter.
// Optional peak hold is enabled by defining TAPE_METER_HOLD_EN.
package tape_meter_pkg;

  localparam int         POS_W   = 25;
  localparam logic [7:0] SILENCE = 8'h80;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_HIDDEN = 2'd2
  } state_e;

  // Full-wave rectify an offset-binary sample and scale it to 0..254.
  function automatic logic [7:0] rectify(input logic [7:0] s);
    logic [6:0] mag;
    if (s >= SILENCE) mag = 7'(s - SILENCE);
    else              mag = 7'(8'h7F - s);
    return {mag, 1'b0};
  endfunction

endpackage

// File: rtl/tape_env.sv
// Rectify + peak envelope pipeline. Stage 1 registers the rectified level,
// stage 2 applies attack / hold / decay, so env moves two cycles after a strobe.
// Peak hold exists only when TAPE_METER_HOLD_EN is defined.
module tape_env
  import tape_meter_pkg::*;
#(
  parameter logic [7:0] DECAY_STEP = 8'd4
`ifdef TAPE_METER_HOLD_EN
  , parameter logic [7:0] HOLD_TICKS = 8'd20
`endif
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       sample_stb,
  input  logic [7:0] sample,
  input  logic       tick,
  input  logic       clr,
  output logic [7:0] env
);

  logic [7:0] lvl_q, lvl_d;
  logic       vld_q, vld_d;
  logic [7:0] env_q, env_d;
  logic       attack;
`ifdef TAPE_METER_HOLD_EN
  logic [7:0] hold_q, hold_d;
`endif

  // Stage 1: capture the rectified level whenever a sample is qualified.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    lvl_d = lvl_q;
    vld_d = sample_stb;
    if (sample_stb) lvl_d = rectify(sample);
  end

  // Stage 2: attack beats a same-cycle tick; a load clears everything.
  always_comb begin
    env_d  = env_q;
`ifdef TAPE_METER_HOLD_EN
    hold_d = hold_q;
`endif
    attack = vld_q && (lvl_q > env_q);
    if (clr) begin
      env_d  = 8'd0;
`ifdef TAPE_METER_HOLD_EN
      hold_d = 8'd0;
`endif
    end else if (attack) begin
      env_d  = lvl_q;
`ifdef TAPE_METER_HOLD_EN
      hold_d = HOLD_TICKS;
`endif
    end else if (tick) begin
`ifdef TAPE_METER_HOLD_EN
      if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
      else env_d = (env_q >= DECAY_STEP) ? env_q - DECAY_STEP : 8'd0;
`else
      env_d = (env_q >= DECAY_STEP) ? env_q - DECAY_STEP : 8'd0;
`endif
    end
  end

  // Pipeline and envelope registers; reset also drops an in-flight sample.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    if (reset) begin
      lvl_q  <= 8'd0;
      vld_q  <= 1'b0;
      env_q  <= 8'd0;
`ifdef TAPE_METER_HOLD_EN
      hold_q <= 8'd0;
`endif
    end else begin
      lvl_q  <= lvl_d;
      vld_q  <= vld_d;
      env_q  <= env_d;
`ifdef TAPE_METER_HOLD_EN
      hold_q <= hold_d;
`endif
    end
  end

  assign env = env_q;

endmodule

// File: rtl/tape_meter.sv
// Cassette OSD feeder: envelope level, byte position against file size, and
// overlay visibility with an idle timeout. Define TAPE_METER_HOLD_EN for peak hold.
module tape_meter
  import tape_meter_pkg::*;
#(
  parameter logic [7:0]  DECAY_STEP = 8'd4,
  parameter logic [11:0] IDLE_TICKS = 12'd2000
`ifdef TAPE_METER_HOLD_EN
  , parameter logic [7:0] HOLD_TICKS = 8'd20
`endif
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             sample_stb,
  input  logic [7:0]       sample,
  input  logic             file_load,
  input  logic [POS_W-1:0] file_size,
  input  logic             byte_stb,
  input  logic [POS_W-1:0] byte_addr,
  output logic [7:0]       tape_data,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] max,
  output logic             ena
);

  state_e           state_q, state_d;
  logic [11:0]      idle_q, idle_d;
  logic             ena_q, ena_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] max_q, max_d;
  logic [POS_W:0]   next_pos;

  tape_env #(
    .DECAY_STEP (DECAY_STEP)
`ifdef TAPE_METER_HOLD_EN
    , .HOLD_TICKS (HOLD_TICKS)
`endif
  ) u_env (
    .i_clk      (i_clk),
    .reset      (reset),
    .sample_stb (sample_stb),
    .sample     (sample),
    .tick       (tick),
    .clr        (file_load),
    .env        (tape_data)
  );

  // Position: one past the consumed byte, clamped to the file size, with a
  // wide sum so the top address cannot wrap back to zero.
  always_comb begin
    pos_d    = pos_q;
    max_d    = max_q;
    next_pos = {1'b0, byte_addr} + {{POS_W{1'b0}}, 1'b1};
    if (file_load) begin
      max_d = file_size;
      pos_d = '0;
    end else if (byte_stb && (max_q != '0)) begin
      pos_d = (next_pos > {1'b0, max_q}) ? max_q : next_pos[POS_W-1:0];
    end
  end

  // Overlay FSM next state: a load overrides everything, a byte reload beats a tick.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    if (file_load) begin
      if (file_size != '0) begin
        state_d = S_ACTIVE;
        idle_d  = IDLE_TICKS;
      end else begin
        state_d = S_EMPTY;
        idle_d  = 12'd0;
      end
    end else begin
      unique case (state_q)
        S_EMPTY: ;
        S_ACTIVE: begin
          if (byte_stb) begin
            idle_d = IDLE_TICKS;
          end else if (tick) begin
            if (idle_q <= 12'd1) begin
              state_d = S_HIDDEN;
              idle_d  = 12'd0;
            end else begin
              idle_d = idle_q - 12'd1;
            end
          end
        end
        S_HIDDEN: begin
          if (byte_stb) begin
            state_d = S_ACTIVE;
            idle_d  = IDLE_TICKS;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    ena_d = (state_d == S_ACTIVE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      idle_q  <= 12'd0;
      ena_q   <= 1'b0;
      pos_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      ena_q   <= ena_d;
      pos_q   <= pos_d;
      max_q   <= max_d;
    end
  end

  assign pos = pos_q;
  assign max = max_q;
  assign ena = ena_q;

endmodule

// File: tb/tb_tape_meter.sv
// Directed bench for tape_meter; expectations follow TAPE_METER_HOLD_EN.
module tb_tape_meter;

  logic        i_clk = 1'b0;
  logic        reset, tick, sample_stb, file_load, byte_stb;
  logic [7:0]  sample;
  logic [24:0] file_size, byte_addr;
  logic [7:0]  tape_data;
  logic [24:0] pos, max;
  logic        ena;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  tape_meter dut (
    .i_clk      (i_clk),
    .reset      (reset),
    .tick       (tick),
    .sample_stb (sample_stb),
    .sample     (sample),
    .file_load  (file_load),
    .file_size  (file_size),
    .byte_stb   (byte_stb),
    .byte_addr  (byte_addr),
    .tape_data  (tape_data),
    .pos        (pos),
    .max        (max),
    .ena        (ena)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic do_sample(input logic [7:0] s);
    sample = s; sample_stb = 1'b1; step(); sample_stb = 1'b0; step();
  endtask

  task automatic do_byte(input logic [24:0] a);
    byte_addr = a; byte_stb = 1'b1; step(); byte_stb = 1'b0;
  endtask

  task automatic do_load(input logic [24:0] sz);
    file_size = sz; file_load = 1'b1; step(); file_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    n_cmp++; if (tape_data !== 8'd0) begin n_bad++; $display("FAIL reset_tape_data: got %0d expected 0", tape_data); end
    n_cmp++; if (pos !== 25'd0) begin n_bad++; $display("FAIL reset_pos: got %0d expected 0", pos); end
    n_cmp++; if (max !== 25'd0) begin n_bad++; $display("FAIL reset_max: got %0d expected 0", max); end
    n_cmp++; if (ena !== 1'b0) begin n_bad++; $display("FAIL reset_ena: got %0b expected 0", ena); end
  endtask

  task automatic test_load();
    do_load(25'd1000);
    n_cmp++; if (max !== 25'd1000) begin n_bad++; $display("FAIL load_max: got %0d expected 1000", max); end
    n_cmp++; if (pos !== 25'd0) begin n_bad++; $display("FAIL load_pos: got %0d expected 0", pos); end
    n_cmp++; if (ena !== 1'b1) begin n_bad++; $display("FAIL load_ena: got %0b expected 1", ena); end
    n_cmp++; if (tape_data !== 8'd0) begin n_bad++; $display("FAIL load_tape_data: got %0d expected 0", tape_data); end
  endtask

  task automatic test_attack_decay();
    int e;
    sample = 8'hFF; sample_stb = 1'b1; step(); sample_stb = 1'b0; sample = 8'h80;
    n_cmp++; if (tape_data !== 8'd0) begin n_bad++; $display("FAIL attack_early: got %0d expected 0", tape_data); end
    step();
    n_cmp++; if (tape_data !== 8'd254) begin n_bad++; $display("FAIL attack_ff: got %0d expected 254", tape_data); end
    do_sample(8'h80);
`ifdef TAPE_METER_HOLD_EN
    for (int i = 0; i < 20; i++) do_tick();
    n_cmp++; if (tape_data !== 8'd254) begin n_bad++; $display("FAIL hold_20: got %0d expected 254", tape_data); end
`endif
    do_tick();
    n_cmp++; if (tape_data !== 8'd250) begin n_bad++; $display("FAIL first_decay: got %0d expected 250", tape_data); end
    e = 250;
    for (int i = 0; i < 64; i++) begin
      do_tick();
      e = (e >= 4) ? e - 4 : 0;
      n_cmp++; if (tape_data !== 8'(e)) begin n_bad++; $display("FAIL decay_%0d: got %0d expected %0d", i, tape_data, e); end
    end
  endtask

  task automatic test_rectify();
    do_sample(8'h00);
    n_cmp++; if (tape_data !== 8'd254) begin n_bad++; $display("FAIL rect_00: got %0d expected 254", tape_data); end
    do_load(25'd1000);
    n_cmp++; if (tape_data !== 8'd0) begin n_bad++; $display("FAIL load_clears_env: got %0d expected 0", tape_data); end
    do_sample(8'hE4);
    n_cmp++; if (tape_data !== 8'd200) begin n_bad++; $display("FAIL rect_e4: got %0d expected 200", tape_data); end
    do_sample(8'h90);
    n_cmp++; if (tape_data !== 8'd200) begin n_bad++; $display("FAIL no_attack_90: got %0d expected 200", tape_data); end
    // Tick lands in the envelope cycle of an attacking sample.
    sample = 8'hF0; sample_stb = 1'b1; step(); sample_stb = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (tape_data !== 8'd224) begin n_bad++; $display("FAIL attack_tick: got %0d expected 224", tape_data); end
    do_tick();
`ifdef TAPE_METER_HOLD_EN
    n_cmp++; if (tape_data !== 8'd224) begin n_bad++; $display("FAIL post_attack_tick: got %0d expected 224", tape_data); end
`else
    n_cmp++; if (tape_data !== 8'd220) begin n_bad++; $display("FAIL post_attack_tick: got %0d expected 220", tape_data); end
`endif
  endtask

  task automatic test_position();
    logic [24:0] addr [5];
    logic [24:0] exp  [5];
    addr = '{25'd998, 25'd999, 25'd5000, 25'h1FFFFFF, 25'd10};
    exp  = '{25'd999, 25'd1000, 25'd1000, 25'd1000, 25'd11};
    for (int i = 0; i < 5; i++) begin
      do_byte(addr[i]);
      n_cmp++; if (pos !== exp[i]) begin n_bad++; $display("FAIL pos_%0d: got %0d expected %0d", i, pos, exp[i]); end
    end
    byte_addr = 25'd10; byte_stb = 1'b1; file_size = 25'd500; file_load = 1'b1;
    step(); byte_stb = 1'b0; file_load = 1'b0;
    n_cmp++; if (pos !== 25'd0) begin n_bad++; $display("FAIL load_beats_byte_pos: got %0d expected 0", pos); end
    n_cmp++; if (max !== 25'd500) begin n_bad++; $display("FAIL load_beats_byte_max: got %0d expected 500", max); end
  endtask

  task automatic test_idle();
    do_byte(25'd0);
    for (int i = 0; i < 1999; i++) do_tick();
    n_cmp++; if (ena !== 1'b1) begin n_bad++; $display("FAIL idle_1999: got %0b expected 1", ena); end
    do_tick();
    n_cmp++; if (ena !== 1'b0) begin n_bad++; $display("FAIL idle_2000: got %0b expected 0", ena); end
    do_byte(25'd1);
    n_cmp++; if (ena !== 1'b1) begin n_bad++; $display("FAIL wake: got %0b expected 1", ena); end
    for (int i = 0; i < 1999; i++) do_tick();
    byte_addr = 25'd2; byte_stb = 1'b1; tick = 1'b1; step(); byte_stb = 1'b0; tick = 1'b0; step();
    n_cmp++; if (ena !== 1'b1) begin n_bad++; $display("FAIL reload_beats_tick: got %0b expected 1", ena); end
    for (int i = 0; i < 1999; i++) do_tick();
    n_cmp++; if (ena !== 1'b1) begin n_bad++; $display("FAIL reload_1999: got %0b expected 1", ena); end
    do_tick();
    n_cmp++; if (ena !== 1'b0) begin n_bad++; $display("FAIL reload_2000: got %0b expected 0", ena); end
  endtask

  task automatic test_empty();
    do_byte(25'd20);
    n_cmp++; if (ena !== 1'b1) begin n_bad++; $display("FAIL pre_empty_ena: got %0b expected 1", ena); end
    do_load(25'd0);
    n_cmp++; if (ena !== 1'b0) begin n_bad++; $display("FAIL empty_ena: got %0b expected 0", ena); end
    n_cmp++; if (pos !== 25'd0) begin n_bad++; $display("FAIL empty_pos: got %0d expected 0", pos); end
    n_cmp++; if (max !== 25'd0) begin n_bad++; $display("FAIL empty_max: got %0d expected 0", max); end
    do_byte(25'd5);
    n_cmp++; if (pos !== 25'd0) begin n_bad++; $display("FAIL empty_byte_pos: got %0d expected 0", pos); end
    n_cmp++; if (ena !== 1'b0) begin n_bad++; $display("FAIL empty_byte_ena: got %0b expected 0", ena); end
  endtask

  task automatic test_reset_mid();
    do_load(25'd1000);
    do_byte(25'd50);
    do_sample(8'hC0);
    n_cmp++; if (tape_data !== 8'd128) begin n_bad++; $display("FAIL pre_reset_env: got %0d expected 128", tape_data); end
    sample = 8'hFF; sample_stb = 1'b1; reset = 1'b1; step(); sample_stb = 1'b0; reset = 1'b0;
    n_cmp++; if (tape_data !== 8'd0) begin n_bad++; $display("FAIL mid_reset_tape_data: got %0d expected 0", tape_data); end
    n_cmp++; if (pos !== 25'd0) begin n_bad++; $display("FAIL mid_reset_pos: got %0d expected 0", pos); end
    n_cmp++; if (max !== 25'd0) begin n_bad++; $display("FAIL mid_reset_max: got %0d expected 0", max); end
    n_cmp++; if (ena !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ena: got %0b expected 0", ena); end
    step(); step();
    n_cmp++; if (tape_data !== 8'd0) begin n_bad++; $display("FAIL inflight_dropped: got %0d expected 0", tape_data); end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; sample_stb = 1'b0; sample = 8'h80;
    file_load = 1'b0; file_size = '0; byte_stb = 1'b0; byte_addr = '0;
    test_reset();
    test_load();
    test_attack_decay();
    test_rectify();
    test_position();
    test_idle();
    test_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tape_meter.md
Name: tape_meter

Overview:
- Upstream feeder for the cassette OSD overlay; produces its `tape_data`, `pos`, `max` and `ena` inputs.
- Rectifies the 8-bit offset-binary cassette playback samples into a peak envelope with hold and decay.
- Tracks the playback byte position against the loaded file size.
- Decides when the overlay is shown: visible while the tape moves, hidden after an idle timeout.

Parameters:
- HOLD_TICKS, 8'd20: number of ticks the envelope peak is held before decay starts.
- DECAY_STEP, 8'd4: amount subtracted from the envelope per tick once the hold has expired.
- IDLE_TICKS, 12'd2000: ticks without a byte strobe before the overlay is hidden.

Ports:
- i_clk  in  1  system clock; all logic is on posedge.
- reset  in  1  synchronous, active-high.
- tick  in  1  1 kHz single-cycle timebase strobe.
- sample_stb  in  1  qualifies `sample`.
- sample  in  8  cassette audio, offset binary, 0x80 = silence.
- file_load  in  1  pulse when a tape image is mounted.
- file_size  in  25  image length in bytes; sampled on `file_load`.
- byte_stb  in  1  the player has consumed byte `byte_addr`.
- byte_addr  in  25  address of the consumed byte.
- tape_data  out  8  envelope level, 0..254.
- pos  out  25  current position, 0..max.
- max  out  25  loaded file size.
- ena  out  1  overlay enable.

Behaviour:
- Reset (already decided): reset is synchronous, active-high; clock is i_clk. Reset drives `tape_data`=0, `pos`=0, `max`=0, `ena`=0, state S_EMPTY and clears all counters. Reset mid-operation discards an in-flight sample.
- Rectify stage (registered on `sample_stb`):
  - mag = (sample>=0x80) ? sample-0x80 : 0x7F-sample, 7 bits.
  - lvl = {mag,1'b0}, giving 0..254.
- Envelope stage (the cycle after stage 1 is valid):
  - Attack: if lvl > env, then env<=lvl and hold<=HOLD_TICKS.
  - `tape_data` updates exactly 2 cycles after `sample_stb`.
  - Back-to-back strobes pipeline fully, one per cycle.
- Decay, on `tick` when no attack occurs in the same cycle:
  - If hold!=0, hold decrements.
  - Otherwise env<=(env>=DECAY_STEP) ? env-DECAY_STEP : 0.
  - Attack and tick in the same cycle: attack wins and the tick is dropped for the envelope.
- Position:
  - On `byte_stb`, pos<=min(byte_addr+1, max).
  - Arithmetic is 25-bit; byte_addr=2^25-1 saturates at max with no wrap.
  - `byte_stb` while max==0 is ignored.
- file_load:
  - max<=file_size, pos<=0, env<=0, hold<=0.
  - `file_load` beats a simultaneous `byte_stb`.
- FSM:
  - S_EMPTY, ena=0: `file_load` with file_size!=0 goes to S_ACTIVE and idle<=IDLE_TICKS.
  - S_ACTIVE, ena=1:
    - `byte_stb` reloads idle<=IDLE_TICKS.
    - `tick` decrements idle.
    - idle==0 on a tick goes to S_HIDDEN.
  - S_HIDDEN, ena=0: `byte_stb` goes to S_ACTIVE and reloads idle.
  - From any state, `file_load` with file_size==0 goes to S_EMPTY with max=0 and pos=0; with file_size!=0 it goes to S_ACTIVE.
  - `tick` and `byte_stb` in the same cycle: the reload wins.
- `ena` is registered and changes 1 cycle after the transition-causing event.

Optional Feature:
- Macro: TAPE_METER_HOLD_EN.
- When defined: peak hold operates as described.
- When undefined: the hold counter and HOLD_TICKS are removed, and decay applies on every `tick` immediately after an attack.

Decomposition:
- Package `tape_meter_pkg` holds:
  - state enum: S_EMPTY=2'd0, S_ACTIVE=2'd1, S_HIDDEN=2'd2.
  - SILENCE=8'h80.
  - POS_W=25.
- Sub-module `tape_env`: the rectify and envelope pipeline with hold/decay; ports sample_stb, sample, tick, clr and env.
- Position tracking and the FSM stay in the top level.

Test Plan:
- Reset, then `file_load` with file_size=1000 → max=1000, pos=0, ena=1 one cycle later, tape_data=0.
- sample=0xFF strobe → tape_data=254 two cycles later. Then sample=0x80 plus 20 ticks → held at 254; 21st tick → 250; continue until 0 with no underflow.
- sample=0x00 → lvl=254. With tape_data=200, sample=0x90 (lvl=32) → no change. Attack plus tick in the same cycle → attack value, no decrement.
- byte_stb with byte_addr=998 → pos=999; byte_addr=999 → pos=1000; byte_addr=5000 → pos stays 1000.
- No byte_stb for 2000 ticks → ena=0 (S_HIDDEN); next byte_stb → ena=1. A byte_stb and tick together at idle=1 → ena stays 1.
- Mid-stream `file_load` with file_size=0 → S_EMPTY, ena=0, pos=0, max=0; later byte_stb ignored. Reset asserted during a sample strobe → all outputs 0 next cycle.
